// File: rtl/spi_frame_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_watchdog
//  Description : Validates SPI frames by header, latches joint commands,
//                enables and digital outputs, and zeroes them when no valid
//                frame arrives within TIMEOUT_CYCLES clock cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_frame_watchdog #(
    parameter int          NUM_JOINTS     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 4800000,
    parameter logic [31:0] HEADER         = 32'h74697277
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rx_strobe,
    input  logic [31:0]              i_rx_header,
    input  logic [NUM_JOINTS*32-1:0] i_rx_joint_cmd,
    input  logic [7:0]               i_rx_enable,
    input  logic [7:0]               i_rx_dout,
    output logic [NUM_JOINTS*32-1:0] o_joint_cmd,
    output logic [7:0]               o_joint_enable,
    output logic [7:0]               o_dout,
    output logic                     o_link_ok,
    output logic [15:0]              o_frame_count,
    output logic [7:0]               o_error_count,
    output logic [7:0]               o_timeout_count
);

    // Last watchdog value before the link is declared lost.
    localparam logic [31:0] c_WDOG_LAST = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t                     r_state;
    logic [31:0]                r_wdog;
    logic [NUM_JOINTS*32-1:0]   r_joint_cmd;
    logic [7:0]                 r_joint_enable;
    logic [7:0]                 r_dout;
    logic [15:0]                r_frame_count;
    logic [7:0]                 r_error_count;
    logic [7:0]                 r_timeout_count;

    logic w_header_ok;
    logic w_accept;
    logic w_reject;
    logic w_expire;

    assign w_header_ok = (i_rx_header == HEADER);
    assign w_accept    = i_rx_strobe & w_header_ok;
    assign w_reject    = i_rx_strobe & ~w_header_ok;
    // Only an ACTIVE link can expire; an accept in the same cycle takes priority.
    assign w_expire    = (r_state == ST_ACTIVE) && (r_wdog == c_WDOG_LAST);

    // Link state machine, watchdog counter, latched data and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_wdog          <= 32'd0;
            r_joint_cmd     <= '0;
            r_joint_enable  <= 8'd0;
            r_dout          <= 8'd0;
            r_frame_count   <= 16'd0;
            r_error_count   <= 8'd0;
            r_timeout_count <= 8'd0;
        end else if (w_accept) begin
            r_state        <= ST_ACTIVE;
            r_wdog         <= 32'd0;
            r_joint_cmd    <= i_rx_joint_cmd;
            r_joint_enable <= i_rx_enable;
            r_dout         <= i_rx_dout;
            r_frame_count  <= r_frame_count + 16'd1;
        end else begin
            if (w_reject && (r_error_count != 8'hFF)) begin
                r_error_count <= r_error_count + 8'd1;
            end
            if (w_expire) begin
                // Counter stays at its last value so it never passes the limit.
                r_state        <= ST_TIMEOUT;
                r_joint_cmd    <= '0;
                r_joint_enable <= 8'd0;
                r_dout         <= 8'd0;
                if (r_timeout_count != 8'hFF) begin
                    r_timeout_count <= r_timeout_count + 8'd1;
                end
            end else if (r_state == ST_ACTIVE) begin
                r_wdog <= r_wdog + 32'd1;
            end
        end
    end

    assign o_joint_cmd     = r_joint_cmd;
    assign o_joint_enable  = r_joint_enable;
    assign o_dout          = r_dout;
    assign o_link_ok       = (r_state == ST_ACTIVE);
    assign o_frame_count   = r_frame_count;
    assign o_error_count   = r_error_count;
    assign o_timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: doc/spi_frame_watchdog.md
SPI_FRAME_WATCHDOG -- requirements
Module: spi_frame_watchdog

Interface
REQ-001 Parameter NUM_JOINTS, default 5: number of 32-bit joint frequency commands carried per frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 4800000: clock cycles without an accepted frame before the link is declared lost (100 ms at 48 MHz).
REQ-003 Parameter HEADER, default 32'h74697277: required frame header value.
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port rx_strobe  input  1  single-cycle pulse from the SPI stage: a complete frame is present on the rx_* inputs.
REQ-007 Port rx_header  input  32  header word of the frame, byte order already restored.
REQ-008 Port rx_joint_cmd  input  NUM_JOINTS*32  joint frequency commands; joint 0 in bits [31:0].
REQ-009 Port rx_enable  input  8  joint enable bits; bit n applies to joint n.
REQ-010 Port rx_dout  input  8  digital output bits.
REQ-011 Port joint_cmd  output  NUM_JOINTS*32  latched, gated joint commands for the stepgen/rcservo stage.
REQ-012 Port joint_enable  output  8  latched, gated joint enables.
REQ-013 Port dout  output  8  latched, gated digital outputs.
REQ-014 Port link_ok  output  1  high while in state ACTIVE.
REQ-015 Port frame_count  output  16  count of accepted frames, wraps modulo 2^16.
REQ-016 Port error_count  output  8  count of rejected frames, saturates at 255.
REQ-017 Port timeout_count  output  8  count of ACTIVE->TIMEOUT transitions, saturates at 255.

Function
REQ-018 States: IDLE (no frame accepted since reset), ACTIVE, TIMEOUT; encoding is free.
REQ-019 Accept: rx_strobe=1 and rx_header==HEADER; reject: rx_strobe=1 and rx_header!=HEADER.
REQ-020 On accept, in any state, the block shall register rx_joint_cmd, rx_enable and rx_dout, reload the watchdog counter to 0, increment frame_count and enter ACTIVE; the new values appear on the outputs on the clock edge following the strobe cycle (1-cycle latency).
REQ-021 On reject, the block shall increment error_count (saturating) and leave the state, the outputs and the watchdog counter unchanged.
REQ-022 In ACTIVE without an accept, the watchdog counter shall increment by 1 each cycle; when it equals TIMEOUT_CYCLES-1 and no accept occurs in that cycle, the next state is TIMEOUT.
REQ-023 Accept in the same cycle as the timeout condition: accept wins; the state stays ACTIVE and the counter reloads to 0.
REQ-024 Entering TIMEOUT shall, on the same edge, zero joint_cmd, joint_enable and dout and increment timeout_count (saturating).
REQ-025 In IDLE and TIMEOUT the watchdog counter shall hold, and joint_cmd, joint_enable and dout shall be 0.
REQ-026 TIMEOUT -> ACTIVE only on accept; no other exit except reset.
REQ-027 The watchdog counter is 32 bits wide and shall never exceed TIMEOUT_CYCLES-1.
REQ-028 Joint commands pass through unmodified (signed two's complement) in ACTIVE; no arithmetic is applied.

Reset
REQ-029 While rst=1, the block shall be in IDLE and every output and counter shall be 0, asynchronously, regardless of clk.
REQ-030 Reset asserted mid-frame or in ACTIVE shall discard the latched data; a rx_strobe coincident with rst shall be ignored.
REQ-031 After rst deasserts, the first accepted frame shall behave exactly as REQ-020.

Verification
REQ-032 Reset, then one strobe with HEADER, joint0=32'h00001000, rx_enable=8'h1F, rx_dout=8'h21 -> next cycle joint_cmd[31:0]=32'h00001000, joint_enable=8'h1F, dout=8'h21, link_ok=1, frame_count=1.
REQ-033 In ACTIVE, strobe with header 32'hDEADBEEF -> outputs unchanged, error_count +1, frame_count unchanged; 300 such strobes -> error_count=255.
REQ-034 TIMEOUT_CYCLES=16: accept, then no strobes -> link_ok falls and all gated outputs are 0 exactly 16 cycles after the accept edge; timeout_count=1.
REQ-035 TIMEOUT_CYCLES=16: accept strobes every 16 cycles, placing one in the timeout cycle -> link_ok never falls, timeout_count stays 0.
REQ-036 In TIMEOUT, accept with joint0=32'hFFFFF000 -> ACTIVE next cycle, joint_cmd[31:0]=32'hFFFFF000; rst pulsed mid-ACTIVE -> all outputs 0 immediately, state IDLE.
REQ-037 frame_count preloaded to 16'hFFFF by 65535 accepts, one more accept -> frame_count=0, link_ok stays 1.
